// File: rtl/saph_trap_walker.sv
`default_nettype none
// ============================================================================
// Module   : saph_trap_walker
// Brief    : Walks rasterizer trapezoids one scanline per cycle, emitting
//            top-left (ceil) sampled spans [x0, x1) for each y.
// Revision : 1.0 - initial release
// ============================================================================
module saph_trap_walker #(
    parameter int COORD_W = 16,
    parameter int FRAC_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [COORD_W-1:0]          in_y_top,
    input  logic [COORD_W-1:0]          in_y_bot,
    input  logic [COORD_W+FRAC_W-1:0]   in_xl,
    input  logic [COORD_W+FRAC_W-1:0]   in_xr,
    input  logic [COORD_W+FRAC_W-1:0]   in_dxl,
    input  logic [COORD_W+FRAC_W-1:0]   in_dxr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [COORD_W-1:0]          out_y,
    output logic [COORD_W-1:0]          out_x0,
    output logic [COORD_W-1:0]          out_x1,
    output logic                        out_last
);

    localparam int c_xw = COORD_W + FRAC_W;
    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_walk = 1'b1;
    localparam logic [c_xw-1:0] c_round = {{COORD_W{1'b0}}, {FRAC_W{1'b1}}};
    localparam logic [COORD_W-1:0] c_one = {{(COORD_W-1){1'b0}}, 1'b1};

    logic [0:0]         r_state;
    logic [COORD_W-1:0] r_y_cur;
    logic [COORD_W-1:0] r_y_end;
    logic [c_xw-1:0]    r_xl;
    logic [c_xw-1:0]    r_xr;
    logic [c_xw-1:0]    r_dxl;
    logic [c_xw-1:0]    r_dxr;

    // The span to present next comes either from a fresh trapezoid (IDLE)
    // or from the edges stepped by one scanline (WALK); one datapath serves both.
    logic               w_idle;
    logic [COORD_W-1:0] w_src_y;
    logic [COORD_W-1:0] w_src_yend;
    logic [c_xw-1:0]    w_src_xl;
    logic [c_xw-1:0]    w_src_xr;
    logic [COORD_W-1:0] w_ceil_l;
    logic [COORD_W-1:0] w_ceil_r;
    logic [COORD_W-1:0] w_x1;
    logic [COORD_W-1:0] w_y_inc;
    logic               w_last;

    assign w_idle     = (r_state == c_idle);
    assign w_src_y    = w_idle ? in_y_top : r_y_cur + c_one;
    assign w_src_yend = w_idle ? in_y_bot : r_y_end;
    assign w_src_xl   = w_idle ? in_xl    : r_xl + r_dxl;
    assign w_src_xr   = w_idle ? in_xr    : r_xr + r_dxr;

    assign w_ceil_l = COORD_W'($signed(w_src_xl + c_round) >>> FRAC_W);
    assign w_ceil_r = COORD_W'($signed(w_src_xr + c_round) >>> FRAC_W);
    // Crossed edges collapse to a zero-width span at x0.
    assign w_x1     = ($signed(w_ceil_r) < $signed(w_ceil_l)) ? w_ceil_l : w_ceil_r;
    assign w_y_inc  = w_src_y + c_one;
    assign w_last   = (w_y_inc == w_src_yend);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_y_cur   <= '0;
            r_y_end   <= '0;
            r_xl      <= '0;
            r_xr      <= '0;
            r_dxl     <= '0;
            r_dxr     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_x0    <= '0;
            out_x1    <= '0;
            out_last  <= 1'b0;
        end else if (r_state == c_idle) begin
            if (in_valid) begin
                r_y_cur <= in_y_top;
                r_y_end <= in_y_bot;
                r_xl    <= in_xl;
                r_xr    <= in_xr;
                r_dxl   <= in_dxl;
                r_dxr   <= in_dxr;
                if (in_y_top < in_y_bot) begin
                    r_state   <= c_walk;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b1;
                    out_y     <= w_src_y;
                    out_x0    <= w_ceil_l;
                    out_x1    <= w_x1;
                    out_last  <= w_last;
                end
            end
        end else begin
            if (out_ready) begin
                r_y_cur <= w_src_y;
                r_xl    <= w_src_xl;
                r_xr    <= w_src_xr;
                if (out_last) begin
                    r_state   <= c_idle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    out_y    <= w_src_y;
                    out_x0   <= w_ceil_l;
                    out_x1   <= w_x1;
                    out_last <= w_last;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_saph_trap_walker.sv
`default_nettype none
// ============================================================================
// Module   : tb_saph_trap_walker
// Brief    : Directed self-checking bench for saph_trap_walker with a span
//            scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_saph_trap_walker;

    typedef struct {
        logic [15:0] y;
        logic [15:0] x0;
        logic [15:0] x1;
        logic        last;
    } span_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_y_top = '0;
    logic [15:0] in_y_bot = '0;
    logic [31:0] in_xl = '0;
    logic [31:0] in_xr = '0;
    logic [31:0] in_dxl = '0;
    logic [31:0] in_dxr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_y;
    logic [15:0] out_x0;
    logic [15:0] out_x1;
    logic        out_last;

    int    checks = 0;
    int    errors = 0;
    span_t sb[$];

    saph_trap_walker #(.COORD_W(16), .FRAC_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_y_top(in_y_top), .in_y_bot(in_y_bot),
        .in_xl(in_xl), .in_xr(in_xr), .in_dxl(in_dxl), .in_dxr(in_dxr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_x0(out_x0), .out_x1(out_x1), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_span(input int y, input int x0, input int x1, input bit last);
        span_t s;
        s.y    = 16'(y);
        s.x0   = 16'(x0);
        s.x1   = 16'(x1);
        s.last = last;
        sb.push_back(s);
    endtask

    task automatic send(input logic [15:0] yt, input logic [15:0] yb,
                        input logic [31:0] xl, input logic [31:0] xr,
                        input logic [31:0] dxl, input logic [31:0] dxr);
        int waited = 0;
        in_valid = 1'b1;
        in_y_top = yt; in_y_bot = yb;
        in_xl = xl; in_xr = xr; in_dxl = dxl; in_dxr = dxr;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("accept_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Scoreboard consumer: every handshaken span must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL span_unexpected observed y=%0d x0=%0d x1=%0d expected none",
                       out_y, $signed(out_x0), $signed(out_x1));
            end
            if (sb.size() != 0) begin
                span_t e;
                e = sb.pop_front();
                check("span_y",    {16'd0, out_y},  {16'd0, e.y});
                check("span_x0",   {16'd0, out_x0}, {16'd0, e.x0});
                check("span_x1",   {16'd0, out_x1}, {16'd0, e.x1});
                check("span_last", {31'd0, out_last}, {31'd0, e.last});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last",  {31'd0, out_last},  32'd0);
        check("rst_outs_zero", {out_y, out_x0 | out_x1}, 32'd0);

        // Basic walk: three back-to-back spans, one bubble before in_ready
        push_span(10, 5, 9, 0); push_span(11, 6, 8, 0); push_span(12, 6, 7, 1);
        send(16'd10, 16'd13, 32'h0005_0000, 32'h0008_8000, 32'h0000_8000, 32'hFFFF_0000);
        check("basic_v0", {31'd0, out_valid}, 32'd1);
        check("basic_rdy_low", {31'd0, in_ready}, 32'd0);
        tick();
        check("basic_v1", {31'd0, out_valid}, 32'd1);
        tick();
        check("basic_v2", {31'd0, out_valid}, 32'd1);
        tick();
        check("basic_done_ready", {31'd0, in_ready}, 32'd1);
        check("basic_done_valid", {31'd0, out_valid}, 32'd0);
        check("basic_sb_empty", sb.size(), 32'd0);

        // Empty trapezoid is swallowed without any span
        send(16'd20, 16'd20, 32'h0001_0000, 32'h0002_0000, 32'd0, 32'd0);
        check("empty_valid", {31'd0, out_valid}, 32'd0);
        check("empty_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("empty_valid2", {31'd0, out_valid}, 32'd0);

        // Crossing edges clamp to zero width
        push_span(0, 4, 5, 0); push_span(1, 5, 5, 0); push_span(2, 6, 6, 1);
        send(16'd0, 16'd3, 32'h0004_0000, 32'h0005_0000, 32'h0001_0000, 32'hFFFF_0000);
        tick(); tick(); tick();
        check("cross_sb_empty", sb.size(), 32'd0);
        check("cross_ready", {31'd0, in_ready}, 32'd1);

        // Backpressure at y=11 for three cycles
        push_span(10, 5, 9, 0); push_span(11, 6, 8, 0); push_span(12, 6, 7, 1);
        send(16'd10, 16'd13, 32'h0005_0000, 32'h0008_8000, 32'h0000_8000, 32'hFFFF_0000);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_y",  {16'd0, out_y},  32'd11);
            check("bp_x",  {out_x0, out_x1}, {16'd6, 16'd8});
            check("bp_last", {31'd0, out_last}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_last_span", {16'd0, out_y}, 32'd12);
        tick();
        check("bp_sb_empty", sb.size(), 32'd0);
        check("bp_ready", {31'd0, in_ready}, 32'd1);

        // Negative coordinates and ceil rounding
        push_span(5, -1, 3, 1);
        send(16'd5, 16'd6, 32'hFFFE_8000, 32'h0002_0001, 32'd0, 32'd0);
        tick();
        check("neg_sb_empty", sb.size(), 32'd0);
        check("neg_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a walk discards the rest
        push_span(10, 5, 9, 0); push_span(11, 6, 8, 0); push_span(12, 6, 7, 1);
        send(16'd10, 16'd13, 32'h0005_0000, 32'h0008_8000, 32'h0000_8000, 32'hFFFF_0000);
        tick();
        check("mid_y11", {16'd0, out_y}, 32'd11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid", {31'd0, out_valid}, 32'd0);
        check("mid_ready", {31'd0, in_ready}, 32'd1);
        check("mid_zero", {out_y, out_x0 | out_x1}, 32'd0);
        check("mid_last", {31'd0, out_last}, 32'd0);
        check("mid_sb_left", sb.size(), 32'd2);
        sb.delete();
        tick();
        check("mid_quiet", {31'd0, out_valid}, 32'd0);
        push_span(0, 4, 5, 0); push_span(1, 5, 5, 0); push_span(2, 6, 6, 1);
        send(16'd0, 16'd3, 32'h0004_0000, 32'h0005_0000, 32'h0001_0000, 32'hFFFF_0000);
        tick(); tick(); tick();
        check("post_rst_sb_empty", sb.size(), 32'd0);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
